// File: rtl/video_timing_pkg.sv
// video_timing_pkg: 720p60 default timing constants and colour bar palette shared by the timing generator
package video_timing_pkg;
    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 110;
    localparam int H_SYNC_720P   = 40;
    localparam int H_BP_720P     = 220;
    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 5;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    // Pixels are packed {B,G,R}; index 0 is the leftmost bar
    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'h00FFFF;
    localparam logic [23:0] BAR_CYAN    = 24'hFFFF00;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'h0000FF;
    localparam logic [23:0] BAR_BLUE    = 24'hFF0000;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;
    localparam logic [7:0][23:0] BAR_COLOURS = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                                BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};
endpackage

// File: rtl/video_timing_gen_colour_bar_gen.sv
// colour_bar_gen: eight vertical colour bars selected from the column address, registered one cycle
module colour_bar_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_720P
) (
    input  logic        hdmi_clk,
    input  logic        reset,
    input  logic [11:0] pix_x,
    output logic [23:0] bar_rgb
);
    localparam int BAR_W = (H_ACTIVE < 8) ? 1 : H_ACTIVE / 8;

    logic [11:0] w_idx;
    logic [23:0] r_bar;

    assign w_idx   = pix_x / 12'(BAR_W);
    assign bar_rgb = r_bar;

    // Register the bar colour so it lands in the same cycle as the upstream pixel data
    always_ff @(posedge hdmi_clk) begin
        if (reset) r_bar <= '0;
        else       r_bar <= BAR_COLOURS[(w_idx > 12'd7) ? 3'd7 : w_idx[2:0]];
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing, pixel request and sync/data alignment for an HDMI transmitter
// Optional colour bar source enabled by defining VIDEO_TIMING_TEST_PATTERN_EN
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   V_ACTIVE = V_ACTIVE_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1
) (
    input  logic        hdmi_clk,
    input  logic        reset,
    input  logic        pattern_on,
    input  logic [23:0] pixel_rgb,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_req,
    output logic        frame_start,
    output logic [2:0]  hve_sync,
    output logic [23:0] rgb
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC;

    logic [11:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic        r_hold;
    logic        r_de;
    logic        r_vs;
    logic        r_hs;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_active;
    logic        w_hs;
    logic        w_vs;
    logic [23:0] w_src;

    assign w_h_last = r_h_cnt == 12'(H_TOTAL - 1);
    assign w_v_last = r_v_cnt == 11'(V_TOTAL - 1);
    assign w_active = !r_hold && (r_h_cnt < 12'(H_ACTIVE)) && (r_v_cnt < 11'(V_ACTIVE));
    assign w_hs     = (r_h_cnt >= 12'(H_SS)) && (r_h_cnt < 12'(H_SE));
    assign w_vs     = (r_v_cnt >= 11'(V_SS)) && (r_v_cnt < 11'(V_SE));

    assign pix_x       = r_h_cnt;
    assign pix_y       = r_v_cnt;
    assign pix_req     = w_active;
    assign frame_start = !r_hold && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign hve_sync    = {r_de, r_vs, r_hs};
    assign rgb         = r_de ? w_src : 24'h000000;

    // Raster counters; r_hold parks them at (0,0) for the reset-release edge so the
    // first free-running cycle presents the frame origin
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_hold  <= 1'b1;
        end else if (r_hold) begin
            r_hold  <= 1'b0;
        end else begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 12'd1;
            if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + 11'd1;
        end
    end

    // Stage 1: sync and enable delayed one cycle to meet the upstream pixel latency
    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            r_de <= 1'b0;
            r_vs <= !VS_POL;
            r_hs <= !HS_POL;
        end else begin
            r_de <= w_active;
            r_vs <= w_vs ? VS_POL : !VS_POL;
            r_hs <= w_hs ? HS_POL : !HS_POL;
        end
    end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
    logic [23:0] w_bar;

    colour_bar_gen #(.H_ACTIVE(H_ACTIVE)) u_bar (
        .hdmi_clk (hdmi_clk),
        .reset    (reset),
        .pix_x    (r_h_cnt),
        .bar_rgb  (w_bar)
    );

    assign w_src = pattern_on ? w_bar : pixel_rgb;
`else
    logic w_unused_pattern;

    assign w_unused_pattern = pattern_on;
    assign w_src            = pixel_rgb;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: randomized scoreboard bench for video_timing_gen on a reduced raster
module tb_video_timing_gen;
    localparam int   HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int   VA = 6, VF = 1, VS = 2, VB = 2;
    localparam logic HP = 1'b1, VP = 1'b0;
    localparam int   HT = HA + HF + HS + HB;
    localparam int   VT = VA + VF + VS + VB;

    typedef struct {
        logic [11:0] x;
        logic [10:0] y;
        logic        req;
        logic        fs;
        logic [2:0]  hve;
        logic [23:0] rgb;
    } exp_t;

    logic        hdmi_clk = 1'b0;
    logic        reset = 1'b1;
    logic        pattern_on = 1'b0;
    logic [23:0] pixel_rgb = '0;
    logic [11:0] pix_x;
    logic [10:0] pix_y;
    logic        pix_req;
    logic        frame_start;
    logic [2:0]  hve_sync;
    logic [23:0] rgb;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    logic done = 1'b0;

    logic [23:0] colours [8] = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
                                 24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};

    logic        m_rst = 1'b1;
    int          n = 0;
    int          p_x = 0, p_y = 0;
    logic        p_req = 1'b0, p_hs = 1'b0, p_vs = 1'b0;
    logic [11:0] d_x = '0;
    logic [10:0] d_y = '0;
    logic        d_req = 1'b0;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HP), .VS_POL(VP)
    ) dut (
        .hdmi_clk    (hdmi_clk),
        .reset       (reset),
        .pattern_on  (pattern_on),
        .pixel_rgb   (pixel_rgb),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_req     (pix_req),
        .frame_start (frame_start),
        .hve_sync    (hve_sync),
        .rgb         (rgb)
    );

    always #5 hdmi_clk = ~hdmi_clk;

    function automatic logic [23:0] source(input int x, input int y);
        int idx;
        logic [7:0] xb, yb;
        idx = x / (HA / 8);
        if (idx > 7) idx = 7;
        xb = 8'(x);
        yb = 8'(y);
`ifdef VIDEO_TIMING_TEST_PATTERN_EN
        if (pattern_on) return colours[idx];
`endif
        return {8'h00, yb, xb};
    endfunction

    task automatic step(input logic r);
        exp_t e;
        int h, v;
        logic hs_c, vs_c;
        reset = r;
        @(posedge hdmi_clk);
        #1;
        if (r) m_rst = 1'b1;
        if (r || m_rst) n = 0; else n++;
        if (!r && m_rst) m_rst = 1'b0;
        h = n % HT;
        v = (n / HT) % VT;
        hs_c = h >= HA + HF && h < HA + HF + HS;
        vs_c = v >= VA + VF && v < VA + VF + VS;
        e.x   = 12'(h);
        e.y   = 11'(v);
        e.req = !m_rst && h < HA && v < VA;
        e.fs  = !m_rst && h == 0 && v == 0;
        e.hve = r ? {1'b0, !VP, !HP} : {p_req, p_vs ? VP : !VP, p_hs ? HP : !HP};
        e.rgb = e.hve[2] ? source(p_x, p_y) : 24'h000000;
        pixel_rgb = d_req ? {8'h00, d_y[7:0], d_x[7:0]} : 24'($urandom);
        if (!d_req && pattern_on) pixel_rgb = 24'($urandom);
        d_x = pix_x;
        d_y = pix_y;
        d_req = pix_req;
        p_x = h;
        p_y = v;
        p_req = e.req;
        p_hs = hs_c && !m_rst;
        p_vs = vs_c && !m_rst;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (x=%0d y=%0d)", name, act, exp, pix_x, pix_y);
        end
    endtask

    int cyc = 0;
    int last_fs = -1;

    always @(negedge hdmi_clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pix_x", 24'(pix_x), 24'(e.x));
            chk("pix_y", 24'(pix_y), 24'(e.y));
            chk("pix_req", 24'(pix_req), 24'(e.req));
            chk("frame_start", 24'(frame_start), 24'(e.fs));
            chk("hve_sync", 24'(hve_sync), 24'(e.hve));
            chk("rgb", rgb, e.rgb);
        end
        if (reset) last_fs = -1;
        else if (frame_start) begin
            if (last_fs >= 0) chk("frame_period", 24'(cyc - last_fs), 24'(HT * VT));
            last_fs = cyc;
        end
        cyc++;
    end

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1);
        for (int i = 0; i < 3 * HT * VT; i++) step(1'b0);
        for (int i = 0; i < 2 * HT * VT; i++) begin
            step(1'b0);
            if (p_x == 7 && p_y == 4) break;
        end
        step(1'b1);
        for (int i = 0; i < HT * VT + 40; i++) step(1'b0);
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 299) == 0);
        step(1'b1);
        pattern_on = 1'b1;
        step(1'b1);
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b0);
        step(1'b1);
        pattern_on = 1'b0;
        for (int i = 0; i < HT * VT; i++) step(1'b0);
        @(negedge hdmi_clk);
        @(negedge hdmi_clk);
        chk("queue_drained", 24'(q.size()), 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
